bsg_cache_sbuf_deep: RTL and testbench
======================================

Name: bsg_cache_sbuf_deep

Overview:
Parametrised-depth store buffer for the bsg_cache data-array write path. It generalises the 2-entry store buffer to els_p entries organised as a circular queue. It optionally coalesces back-to-back stores to the same word, and provides youngest-wins byte bypass across every valid entry plus the incoming store. It sits between the tag-lookup stage (producer, valid-only) and the data-array write port (consumer, valid-yumi).

Parameters:
data_width_p, "inv", store data width in bits; multiple of 8; data_mask_width_lp = data_width_p/8.
addr_width_p, "inv", byte address width.
ways_p, "inv", cache associativity; sets the width of the way_id field in an entry.
els_p, 4, queue depth; any integer >= 2, not required to be a power of two.
coalesce_p, 1, 1 = merge an incoming store into the youngest non-head entry on a word+way match; 0 = never merge.

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous, active-high reset.
sbuf_entry_i  in  sbuf_entry_width_lp  incoming entry {way_id, addr, data, mask} (bsg_cache_sbuf_entry_s layout).
v_i  in  1  incoming entry valid; valid-only, no back-pressure.
sbuf_entry_o  out  sbuf_entry_width_lp  head entry.
v_o  out  1  head valid.
yumi_i  in  1  consumer takes the head this cycle; legal only when v_o=1.
empty_o  out  1  count == 0.
full_o  out  1  count == els_p.
count_o  out  clog2(els_p+1)  number of occupied entries.
bypass_addr_i  in  addr_width_p  load byte address to snoop.
bypass_v_i  in  1  capture bypass result this cycle.
bypass_data_o  out  data_width_p  registered merged bypass data.
bypass_mask_o  out  data_mask_width_lp  registered merged bypass byte mask.

Behaviour:
- Reset (asynchronous, active-high):
  - count, head pointer, tail pointer, bypass_data_o and bypass_mask_o clear to 0 immediately.
  - Outputs during and after reset: v_o=0 (with v_i=0), empty_o=1, full_o=0, count_o=0.
  - Entry storage is not reset.
  - Reset asserted mid-operation discards all entries; a yumi_i in that cycle has no effect.
- Storage: els_p-entry array with head (oldest) and tail (next free) pointers. Pointers wrap from els_p-1 to 0 by compare, not by power-of-two truncation.
- Empty passthrough (count=0):
  - v_o=v_i, sbuf_entry_o=sbuf_entry_i, combinationally.
  - v_i & yumi_i: entry consumed; nothing stored; count stays 0.
  - v_i & ~yumi_i: entry stored; count becomes 1.
- count>0: v_o=1 and sbuf_entry_o is the array entry at head. The head entry is never modified while it is the head.
- Merge condition: coalesce_p=1 & v_i & count>=2 & incoming word address (addr[addr_width_p-1:lg(data_mask_width_lp)]) and way_id equal those of the youngest entry (tail-1, wrapped). When it holds:
  - For each byte with mask_i set, write data_i into that byte of the youngest entry.
  - OR the incoming mask into the youngest entry's mask.
  - Keep the youngest entry's original addr low bits.
  - No allocation.
- Merging into the head is forbidden, so count=1 never merges.
- Per-cycle update:
  - alloc = v_i & ~merge & ~(count==0 & yumi_i).
  - deq = yumi_i & count>0.
  - count_next = count + alloc - deq.
  - Tail advances on alloc; head advances on deq.
- Full: when count=els_p, v_i is legal only together with yumi_i in the same cycle, or when it merges. Otherwise v_i is dropped with no state change, and simulation raises $error.
- Simultaneous alloc and deq at full: count unchanged; both pointers advance.
- Bypass (combinational merge, registered output):
  - Per byte, priority order is incoming entry (if v_i) > youngest ... oldest valid entry.
  - Only entries whose word address matches bypass_addr_i contribute.
  - bypass_mask_n = OR of the masks of all matching contributors.
  - Bytes with no contributor are 0.
  - On bypass_v_i, bypass_data_o/bypass_mask_o load the merged values on the next edge; otherwise they hold.
  - Latency: 1 cycle.
- Simulation assertions: count never exceeds els_p; yumi_i never asserted while v_o=0.

Test Plan:
- Reset, then v_i with addr=0x100, data=0xAABBCCDD, mask=4'hF, and yumi_i in the same cycle -> sbuf_entry_o equals the input that cycle; count_o stays 0; empty_o=1.
- Push 4 entries to addr 0x0,0x4,0x8,0xC with yumi_i=0 -> count_o=4, full_o=1. Then yumi_i for 4 cycles -> entries emerge in FIFO order; empty_o=1 after the fourth dequeue.
- At full (els_p=4), v_i & yumi_i every cycle for 10 cycles -> count_o stays 4; output order is preserved across pointer wrap.
- count=2 with youngest entry addr=0x20 way=1 data=0x11223344 mask=4'b0011; push addr=0x22 way=1 data=0xAABB0000 mask=4'b1100 -> no allocation; count_o=2; drained youngest entry shows data=0xAABB3344, mask=4'hF. Repeat with coalesce_p=0 -> count_o=3.
- Oldest entry addr=0x40 mask=4'hF data=0x11111111; youngest addr=0x40 mask=4'b0001 data=0x22; incoming addr=0x40 mask=4'b0010 data=0x3300; bypass_v_i=1, bypass_addr_i=0x40 -> next cycle bypass_data_o=0x11113322, bypass_mask_o=4'hF.
- With 3 entries queued, assert reset_i asynchronously mid-cycle -> count_o=0, v_o=0, bypass outputs=0 before the next edge. After release, a push and pop operates normally.

Source files
------------

// File: rtl/bsg_cache_sbuf_deep.sv
// Deep store buffer for the cache data-array write path: circular queue of els_p entries with
// optional same-word coalescing into the youngest entry and youngest-wins byte bypass.
module bsg_cache_sbuf_deep #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned ways_p       = 2,
  parameter int unsigned els_p        = 4,
  parameter bit          coalesce_p   = 1'b1,
  localparam int unsigned data_mask_width_lp  = data_width_p / 8,
  localparam int unsigned way_id_width_lp     = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int unsigned sbuf_entry_width_lp =
    way_id_width_lp + addr_width_p + data_width_p + data_mask_width_lp,
  localparam int unsigned count_width_lp      = $clog2(els_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [sbuf_entry_width_lp-1:0] sbuf_entry_i,
  input  logic                           v_i,
  output logic [sbuf_entry_width_lp-1:0] sbuf_entry_o,
  output logic                           v_o,
  input  logic                           yumi_i,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [count_width_lp-1:0]      count_o,
  input  logic [addr_width_p-1:0]        bypass_addr_i,
  input  logic                           bypass_v_i,
  output logic [data_width_p-1:0]        bypass_data_o,
  output logic [data_mask_width_lp-1:0]  bypass_mask_o
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);
  localparam int unsigned lg_mask_lp   = $clog2(data_mask_width_lp);
  localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] els_cnt_lp  = count_width_lp'(els_p);

  typedef struct packed {
    logic [way_id_width_lp-1:0]   way_id;
    logic [addr_width_p-1:0]      addr;
    logic [data_width_p-1:0]      data;
    logic [data_mask_width_lp-1:0] mask;
  } entry_s;

  entry_s entries_q [els_p];
  entry_s in_entry, young_entry, merged_entry;

  logic [ptr_width_lp-1:0]   head_q, head_d, tail_q, tail_d, young_ptr;
  logic [count_width_lp-1:0] count_q, count_d;
  logic [data_width_p-1:0]   bypass_data_q, bypass_data_n;
  logic [data_mask_width_lp-1:0] bypass_mask_q, bypass_mask_n;
  logic empty, full, merge, alloc, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [addr_width_p-lg_mask_lp-1:0] word_of(
    input logic [addr_width_p-1:0] a);
    return a[addr_width_p-1:lg_mask_lp];
  endfunction

  assign in_entry    = sbuf_entry_i;
  assign empty       = (count_q == '0);
  assign full        = (count_q == els_cnt_lp);
  assign young_ptr   = (tail_q == '0) ? last_ptr_lp : tail_q - 1'b1;
  assign young_entry = entries_q[young_ptr];

  // Youngest is never the head once count>=2, so merging cannot disturb the entry on the port.
  assign merge = coalesce_p && v_i && (count_q >= count_width_lp'(2))
              && (word_of(in_entry.addr) == word_of(young_entry.addr))
              && (in_entry.way_id == young_entry.way_id);

  // A full-buffer store that neither merges nor coincides with a dequeue is dropped.
  assign alloc = v_i && !merge && !(empty && yumi_i) && !(full && !yumi_i);
  assign deq   = yumi_i && !empty;

  always_comb begin
    merged_entry      = young_entry;
    merged_entry.mask = young_entry.mask | in_entry.mask;
    for (int b = 0; b < int'(data_mask_width_lp); b++) begin
      if (in_entry.mask[b]) merged_entry.data[8*b+:8] = in_entry.data[8*b+:8];
    end
  end

  always_comb begin
    head_d  = deq ? ptr_inc(head_q) : head_q;
    tail_d  = alloc ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + count_width_lp'(alloc) - count_width_lp'(deq);
  end

  // Walk oldest to youngest so younger bytes overwrite older ones; incoming store wins last.
  always_comb begin
    int unsigned idx;
    entry_s      e;
    bypass_data_n = '0;
    bypass_mask_n = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      idx = int'(head_q) + i;
      if (idx >= els_p) idx = idx - els_p;
      e = entries_q[idx[ptr_width_lp-1:0]];
      if ((i < int'(count_q)) && (word_of(e.addr) == word_of(bypass_addr_i))) begin
        for (int b = 0; b < int'(data_mask_width_lp); b++) begin
          if (e.mask[b]) bypass_data_n[8*b+:8] = e.data[8*b+:8];
        end
        bypass_mask_n = bypass_mask_n | e.mask;
      end
    end
    if (v_i && (word_of(in_entry.addr) == word_of(bypass_addr_i))) begin
      for (int b = 0; b < int'(data_mask_width_lp); b++) begin
        if (in_entry.mask[b]) bypass_data_n[8*b+:8] = in_entry.data[8*b+:8];
      end
      bypass_mask_n = bypass_mask_n | in_entry.mask;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      bypass_data_q <= '0;
      bypass_mask_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (bypass_v_i) begin
        bypass_data_q <= bypass_data_n;
        bypass_mask_q <= bypass_mask_n;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc) begin
      entries_q[tail_q] <= in_entry;
    end else if (merge) begin
      entries_q[young_ptr] <= merged_entry;
    end
  end

  assign v_o           = empty ? v_i : 1'b1;
  assign sbuf_entry_o  = empty ? sbuf_entry_i : entries_q[head_q];
  assign empty_o       = empty;
  assign full_o        = full;
  assign count_o       = count_q;
  assign bypass_data_o = bypass_data_q;
  assign bypass_mask_o = bypass_mask_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
      assert (count_q <= els_cnt_lp) else $error("count exceeds els_p");
      assert (!(v_i && full && !yumi_i && !merge)) else $error("store dropped at full");
    end
  end

endmodule

// File: tb/tb_bsg_cache_sbuf_deep.sv
// Scoreboard bench: stimulus queues expected head entries; a monitor checks every dequeue.
module tb_bsg_cache_sbuf_deep;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned MW  = 4;
  localparam int unsigned EW  = 1 + AW + DW + MW;
  localparam int unsigned CW  = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_i;
  logic [EW-1:0] entry_in;
  logic          v_i, yumi_i, bypass_v_i;
  logic [AW-1:0] bypass_addr_i;

  logic [EW-1:0] entry_o0, entry_o1;
  logic          v_o0, v_o1, empty_o0, empty_o1, full_o0, full_o1;
  logic [CW-1:0] count_o0, count_o1;
  logic [DW-1:0] byp_data0, byp_data1;
  logic [MW-1:0] byp_mask0, byp_mask1;

  bsg_cache_sbuf_deep #(
    .data_width_p(DW), .addr_width_p(AW), .ways_p(2), .els_p(4), .coalesce_p(1'b1)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sbuf_entry_i(entry_in), .v_i(v_i),
    .sbuf_entry_o(entry_o0), .v_o(v_o0), .yumi_i(yumi_i), .empty_o(empty_o0),
    .full_o(full_o0), .count_o(count_o0), .bypass_addr_i(bypass_addr_i),
    .bypass_v_i(bypass_v_i), .bypass_data_o(byp_data0), .bypass_mask_o(byp_mask0)
  );

  bsg_cache_sbuf_deep #(
    .data_width_p(DW), .addr_width_p(AW), .ways_p(2), .els_p(4), .coalesce_p(1'b0)
  ) dut_nc (
    .clk_i(clk_i), .reset_i(reset_i), .sbuf_entry_i(entry_in), .v_i(v_i),
    .sbuf_entry_o(entry_o1), .v_o(v_o1), .yumi_i(yumi_i), .empty_o(empty_o1),
    .full_o(full_o1), .count_o(count_o1), .bypass_addr_i(bypass_addr_i),
    .bypass_v_i(bypass_v_i), .bypass_data_o(byp_data1), .bypass_mask_o(byp_mask1)
  );

  logic [EW-1:0] sb_q [$];
  int total = 0;
  int bad   = 0;

  function automatic logic [EW-1:0] mk(input logic w, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    return {w, a, d, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    v_i        = 1'b0;
    yumi_i     = 1'b0;
    bypass_v_i = 1'b0;
  endtask

  task automatic send(input logic [EW-1:0] e, input logic y);
    entry_in = e;
    v_i      = 1'b1;
    yumi_i   = y;
    tick();
    idle();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      v_i    = 1'b0;
      yumi_i = 1'b1;
      tick();
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Monitor: every accepted head is checked against the oldest expected entry.
  always @(negedge clk_i) begin
    logic [EW-1:0] exp_e;
    if (!reset_i && v_o0 && yumi_i) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL head_unexpected: got %0h expected none", entry_o0);
      end else begin
        exp_e = sb_q.pop_front();
        if (entry_o0 !== exp_e) begin
          bad++;
          $display("FAIL head_entry: got %0h expected %0h", entry_o0, exp_e);
        end
      end
    end
  end

  initial begin
    logic [EW-1:0] e;
    idle();
    entry_in      = '0;
    bypass_addr_i = '0;
    reset_i       = 1'b1;
    #3;
    check("reset_count", 64'(count_o0), 64'd0);
    check("reset_empty", 64'(empty_o0), 64'd1);
    check("reset_full",  64'(full_o0),  64'd0);
    check("reset_v_o",   64'(v_o0),     64'd0);
    check("reset_bypass", {28'd0, byp_mask0, byp_data0}, 64'd0);
    tick();
    reset_i = 1'b0;
    tick();

    // Empty passthrough with same-cycle consume.
    e = mk(1'b0, 16'h0100, 32'hAABBCCDD, 4'hF);
    entry_in = e; v_i = 1'b1; yumi_i = 1'b1;
    sb_q.push_back(e);
    #1;
    check("pass_entry", 64'(entry_o0), 64'(e));
    check("pass_empty", 64'(empty_o0), 64'd1);
    tick();
    idle();
    check("pass_count", 64'(count_o0), 64'd0);

    // Fill then drain in FIFO order.
    for (int i = 0; i < 4; i++) begin
      e = mk(1'b0, 16'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
      sb_q.push_back(e);
      send(e, 1'b0);
    end
    check("fill_count", 64'(count_o0), 64'd4);
    check("fill_full",  64'(full_o0),  64'd1);
    drain(4);
    check("drain_empty", 64'(empty_o0), 64'd1);

    // Full with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      e = mk(1'b0, 16'h0200 + 16'(4 * i), 32'h2000_0000 + 32'(i), 4'hF);
      sb_q.push_back(e);
      send(e, 1'b0);
    end
    for (int i = 4; i < 14; i++) begin
      e = mk(1'b0, 16'h0200 + 16'(4 * i), 32'h2000_0000 + 32'(i), 4'hF);
      sb_q.push_back(e);
      send(e, 1'b1);
      check("wrap_count", 64'(count_o0), 64'd4);
    end
    drain(4);
    check("wrap_empty", 64'(empty_o0), 64'd1);

    // Coalesce into youngest; the non-coalescing instance allocates instead.
    do_reset();
    e = mk(1'b0, 16'h0010, 32'h0000_0055, 4'hF);
    sb_q.push_back(e);
    send(e, 1'b0);
    send(mk(1'b1, 16'h0020, 32'h1122_3344, 4'b0011), 1'b0);
    send(mk(1'b1, 16'h0022, 32'hAABB_0000, 4'b1100), 1'b0);
    sb_q.push_back(mk(1'b1, 16'h0020, 32'hAABB_3344, 4'hF));
    check("merge_count",    64'(count_o0), 64'd2);
    check("nomerge_count",  64'(count_o1), 64'd3);
    drain(2);

    // Bypass: incoming > youngest > oldest, per byte.
    do_reset();
    e = mk(1'b0, 16'h0040, 32'h1111_1111, 4'hF);
    sb_q.push_back(e);
    send(e, 1'b0);
    send(mk(1'b0, 16'h0040, 32'h0000_0022, 4'b0001), 1'b0);
    sb_q.push_back(mk(1'b0, 16'h0040, 32'h0000_3322, 4'b0011));
    entry_in = mk(1'b0, 16'h0040, 32'h0000_3300, 4'b0010);
    v_i = 1'b1; bypass_v_i = 1'b1; bypass_addr_i = 16'h0040;
    tick();
    idle();
    check("byp_data", 64'(byp_data0), 64'h1111_3322);
    check("byp_mask", 64'(byp_mask0), 64'hF);
    check("byp_data_nc", 64'(byp_data1), 64'h1111_3322);
    bypass_v_i = 1'b1; bypass_addr_i = 16'h0080;
    tick();
    idle();
    check("byp_miss", {28'd0, byp_mask0, byp_data0}, 64'd0);
    bypass_addr_i = 16'h0040;
    tick();
    check("byp_hold", {28'd0, byp_mask0, byp_data0}, 64'd0);
    drain(2);

    // Asynchronous reset with three entries queued.
    do_reset();
    send(mk(1'b0, 16'h0000, 32'hCAFE_F00D, 4'hF), 1'b0);
    send(mk(1'b0, 16'h0004, 32'h0000_0004, 4'hF), 1'b0);
    entry_in = mk(1'b0, 16'h0008, 32'h0000_0008, 4'hF);
    v_i = 1'b1; bypass_v_i = 1'b1; bypass_addr_i = 16'h0000;
    tick();
    idle();
    check("pre_rst_count", 64'(count_o0), 64'd3);
    check("pre_rst_byp",   64'(byp_data0), 64'hCAFE_F00D);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_count", 64'(count_o0), 64'd0);
    check("arst_v_o",   64'(v_o0),     64'd0);
    check("arst_byp",   {28'd0, byp_mask0, byp_data0}, 64'd0);
    tick();
    reset_i = 1'b0;
    e = mk(1'b1, 16'h0300, 32'h5A5A_A5A5, 4'b0110);
    sb_q.push_back(e);
    send(e, 1'b0);
    check("post_rst_count", 64'(count_o0), 64'd1);
    drain(1);
    check("post_rst_empty", 64'(empty_o0), 64'd1);

    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
